// File: rtl/heroe_pkg.sv
// Purpose: shared constants for the obstacle receiver: top-level state codes, hero glyphs, local FSM and type-pipeline entry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package heroe_pkg;

    // Top-level game states, shared with the top-level FSM
    localparam logic [2:0] OFF   = 3'd0;
    localparam logic [2:0] MENU  = 3'd1;
    localparam logic [2:0] CH    = 3'd2;
    localparam logic [2:0] GAME  = 3'd3;
    localparam logic [2:0] FINAL = 3'd4;
    localparam logic [2:0] PA    = 3'd5;

    // Hero glyphs, segment order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_PIE      = 7'b0011100;
    localparam logic [6:0] SEG_SALTO    = 7'b1100011;
    localparam logic [6:0] SEG_AGACHADO = 7'b0001000;
    localparam logic [6:0] SEG_BLANK    = 7'd0;

    // Receiver FSM
    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        JUEGO   = 2'd1,
        IMPACTO = 2'd2,
        FIN     = 2'd3
    } fase_t;

    // One obstacle slot of the type pipeline
    typedef struct packed {
        logic valid;
        logic alto;
    } tipo_t;

endpackage

// File: rtl/sincronizador_boton.sv
// Purpose: 2-flop synchronizer for an asynchronous button, plus a rising-edge pulse.
// Latency: level 2 clk after the input; edge pulse is 1 clk wide, 2 clk after the rising input.
// Backpressure: none.
// Ports: boton (async in), nivel (synchronized level), flanco (one-clk rising-edge pulse).
module sincronizador_boton (
    input  logic clk,
    input  logic rst_n,
    input  logic boton,
    output logic nivel,
    output logic flanco
);

    // sr[0], sr[1] form the synchronizer; sr[2] is the previous synced level for edge detect
    logic [2:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[1:0], boton};
        end
    end

    assign nivel  = sr[1];
    assign flanco = sr[1] & ~sr[2];

endmodule

// File: rtl/receptor_obstaculos.sv
// Purpose: tracks obstacles across the three digits, judges avoid/hit at the hero digit, keeps lives/score, drives hero glyph.
// Latency: impacto/gano/perdio pulse 2 clk after the display change that puts an obstacle on the hero digit.
// Backpressure: none; the generator is never stalled, and the PA state freezes all internal state instead.
// Ports: presente (top state), display_obs/tipo_obs (generator stream), btn_salto/btn_agachar (async buttons),
//        vidas, puntos, impacto, gano, perdio, heroe_seg.
module receptor_obstaculos
    import heroe_pkg::*;
#(
    parameter int VIDAS_INI    = 3,
    parameter int META         = 20,
    parameter int SALTO_CICLOS = 13500000,
    parameter int BLINK_CICLOS = 6750000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  presente,
    input  logic [20:0] display_obs,
    input  logic [3:0]  tipo_obs,
    input  logic        btn_salto,
    input  logic        btn_agachar,
    output logic [2:0]  vidas,
    output logic [7:0]  puntos,
    output logic        impacto,
    output logic        gano,
    output logic        perdio,
    output logic [6:0]  heroe_seg
);

    localparam int SW   = $clog2(SALTO_CICLOS + 1);
    localparam int BW   = $clog2(BLINK_CICLOS + 1);
    localparam int FASE = (BLINK_CICLOS / 4 > 0) ? BLINK_CICLOS / 4 : 1;
    localparam int FW   = $clog2(FASE + 1);

    localparam logic [SW-1:0] SALTO_LD = SW'(SALTO_CICLOS);
    localparam logic [BW-1:0] BLINK_LD = BW'(BLINK_CICLOS);
    localparam logic [FW-1:0] FASE_LD  = FW'(FASE - 1);
    localparam logic [2:0]    VIDAS_LD = 3'(VIDAS_INI);
    localparam logic [7:0]    META_V   = 8'(META);

    logic          salto_nivel_unused, salto_flanco;
    logic          agachar_nivel, agachar_flanco_unused;
    logic [2:0]    tipo_rsv_unused;
    logic [20:0]   disp_q;
    logic          cambio, cambio_q, llegada, pausa, activo;
    tipo_t         tp2, tp1, tp0;
    logic [SW-1:0] salto_cnt;
    logic [BW-1:0] blink_cnt;
    logic [FW-1:0] fase_cnt;
    logic          apagado;
    fase_t         estado;
    logic          salto_act, agachar_act, esquiva;
    logic [7:0]    puntos_inc;
    logic [2:0]    vidas_dec;
    logic [6:0]    glifo;

    sincronizador_boton u_sync_salto (
        .clk    (clk),
        .rst_n  (rst_n),
        .boton  (btn_salto),
        .nivel  (salto_nivel_unused),
        .flanco (salto_flanco)
    );

    sincronizador_boton u_sync_agachar (
        .clk    (clk),
        .rst_n  (rst_n),
        .boton  (btn_agachar),
        .nivel  (agachar_nivel),
        .flanco (agachar_flanco_unused)
    );

    // Only bit 0 of the type (low/high) matters to the receiver
    assign tipo_rsv_unused = tipo_obs[3:1];

    assign pausa       = (presente == PA);
    assign activo      = (estado == JUEGO) || (estado == IMPACTO);
    assign cambio      = (display_obs != disp_q);
    // cambio_q is a single-cycle flag, so each obstacle is judged exactly once
    assign llegada     = cambio_q & tp0.valid;
    assign salto_act   = (salto_cnt != '0);
    assign agachar_act = agachar_nivel & ~salto_act;
    assign esquiva     = tp0.alto ? agachar_act : salto_act;
    assign puntos_inc  = (puntos == 8'hFF) ? puntos : puntos + 8'd1;
    assign vidas_dec   = (vidas == 3'd0) ? vidas : vidas - 3'd1;
    assign glifo       = salto_act ? SEG_SALTO : (agachar_act ? SEG_AGACHADO : SEG_PIE);

    // Change detect, obstacle type pipeline and jump timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q    <= '0;
            cambio_q  <= 1'b0;
            tp2       <= '0;
            tp1       <= '0;
            tp0       <= '0;
            salto_cnt <= '0;
        end else begin
            // disp_q keeps tracking during pause so a paused change is not replayed on resume
            disp_q   <= display_obs;
            cambio_q <= cambio & ~pausa & activo;
            if (estado == ESPERA) begin
                tp2       <= '0;
                tp1       <= '0;
                tp0       <= '0;
                salto_cnt <= '0;
            end else if (!pausa) begin
                if (cambio && activo) begin
                    tp2 <= '{valid: |display_obs[20:14], alto: tipo_obs[0]};
                    tp1 <= tp2;
                    tp0 <= tp1;
                end
                // No re-trigger while a jump is still running
                if (salto_flanco && !salto_act) begin
                    salto_cnt <= SALTO_LD;
                end else if (salto_act) begin
                    salto_cnt <= salto_cnt - SW'(1);
                end
            end
        end
    end

    // Game FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= ESPERA;
            vidas     <= VIDAS_LD;
            puntos    <= '0;
            impacto   <= 1'b0;
            gano      <= 1'b0;
            perdio    <= 1'b0;
            blink_cnt <= '0;
            fase_cnt  <= '0;
            apagado   <= 1'b0;
            heroe_seg <= SEG_PIE;
        end else begin
            impacto   <= 1'b0;
            gano      <= 1'b0;
            perdio    <= 1'b0;
            heroe_seg <= (estado == IMPACTO && apagado) ? SEG_BLANK : glifo;
            if (!pausa) begin
                case (estado)
                    ESPERA: begin
                        vidas  <= VIDAS_LD;
                        puntos <= '0;
                        if (presente == GAME) estado <= JUEGO;
                    end
                    JUEGO, IMPACTO: begin
                        if (presente != GAME) begin
                            estado <= ESPERA;
                        end else begin
                            if (estado == IMPACTO) begin
                                if (fase_cnt == '0) begin
                                    fase_cnt <= FASE_LD;
                                    apagado  <= ~apagado;
                                end else begin
                                    fase_cnt <= fase_cnt - FW'(1);
                                end
                                if (blink_cnt <= BW'(1)) begin
                                    blink_cnt <= '0;
                                    estado    <= JUEGO;
                                end else begin
                                    blink_cnt <= blink_cnt - BW'(1);
                                end
                            end
                            // Later assignments override the blink-timeout transition
                            if (llegada) begin
                                if (esquiva) begin
                                    puntos <= puntos_inc;
                                    if (puntos_inc == META_V) begin
                                        gano   <= 1'b1;
                                        estado <= FIN;
                                    end
                                end else if (estado == JUEGO) begin
                                    // Hits during IMPACTO are ignored: the hero is invulnerable
                                    impacto <= 1'b1;
                                    vidas   <= vidas_dec;
                                    if (vidas_dec == 3'd0) begin
                                        perdio <= 1'b1;
                                        estado <= FIN;
                                    end else begin
                                        estado    <= IMPACTO;
                                        blink_cnt <= BLINK_LD;
                                        fase_cnt  <= FASE_LD;
                                        apagado   <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    FIN: begin
                        if (presente == CH) estado <= ESPERA;
                    end
                    default: estado <= ESPERA;
                endcase
            end
        end
    end

endmodule

// File: doc/receptor_obstaculos.md
Name: receptor_obstaculos

Overview:
- Consumer end of the obstacle stream driven by generador_obstaculos.
- Tracks each obstacle across the three display digits and decides at the hero digit whether the hero avoided it (jump/duck) or was hit.
- Maintains lives and score, and raises win/lose events to the top-level state machine.
- Drives the hero's 7-segment glyph.

Parameters:
- VIDAS_INI, 3, lives loaded at game start (1..7).
- META, 20, obstacles avoided to win (1..255).
- SALTO_CICLOS, 13500000, clk cycles a jump lasts after btn_salto.
- BLINK_CICLOS, 6750000, clk cycles hero glyph blanks after a hit.
- GAME, 3'd3; CH, 3'd2; PA, 3'd5, state encodings shared with the top-level FSM.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- presente  in  3  current top-level state
- display_obs  in  21  obstacle digits from generator; [20:14] far, [6:0] hero digit
- tipo_obs  in  4  obstacle type, valid with a new nonzero [20:14]
- btn_salto  in  1  jump button, asynchronous, active high
- btn_agachar  in  1  duck button, asynchronous level, active high
- vidas  out  3  remaining lives
- puntos  out  8  obstacles avoided
- impacto  out  1  one-clk pulse per hit
- gano  out  1  one-clk pulse when puntos reaches META
- perdio  out  1  one-clk pulse when vidas reaches 0
- heroe_seg  out  7  hero glyph

Behaviour:
- Reset (rst_n=0, async): vidas=VIDAS_INI, puntos=0, impacto=gano=perdio=0, heroe_seg=SEG_PIE, FSM=ESPERA, type pipeline cleared, jump timer 0.
- Buttons pass through 2-flop synchronizers. btn_salto is rising-edge detected.
- Change detect:
  - disp_q holds display_obs from the previous clk; cambio = (display_obs != disp_q).
  - The generator updates display_obs and tipo_obs on the same slow edge, so both are sampled together.
- Type pipeline: tp[2..0], 2 bits each, {valid, alto}. On cambio:
  - tp2 = {|display_obs[20:14], tipo_obs[0]}
  - tp1 = tp2, tp0 = tp1
- Arrival:
  - llegada asserts the clk after cambio if tp0.valid=1.
  - Evaluation is single-shot per obstacle.
- Hero pose:
  - salto_act = jump timer nonzero. A rising edge of btn_salto loads SALTO_CICLOS only when the timer is 0; no re-trigger mid-jump.
  - agachar_act = synced btn_agachar AND NOT salto_act. Jump has priority.
- Avoid rule:
  - alto=0 requires salto_act; alto=1 requires agachar_act.
  - Evaluated in the llegada cycle.
- FSM:
  - ESPERA:
    - vidas=VIDAS_INI, puntos=0, tp cleared, jump timer 0.
    - Goes to JUEGO when presente==GAME.
  - JUEGO, on llegada:
    - Avoided: puntos+1. If the new value equals META, pulse gano and go to FIN.
    - Hit: pulse impacto and decrement vidas. If the new value is 0, pulse perdio and go to FIN; otherwise go to IMPACTO with the blink counter loaded with BLINK_CICLOS.
  - IMPACTO:
    - heroe_seg alternates blank/glyph every BLINK_CICLOS/4 cycles.
    - Arrivals are still evaluated, but a hit does not decrement (invulnerable). Avoids still score.
    - Returns to JUEGO when the counter reaches 0.
  - FIN:
    - Outputs hold.
    - Goes to ESPERA when presente==CH.
  - Any state:
    - presente==PA freezes all counters, timers and tp; arrivals are ignored.
    - presente not in {GAME, PA} from JUEGO or IMPACTO goes to ESPERA.
- Simultaneous events:
  - Avoid that reaches META while in IMPACTO: gano still fires.
  - vidas and puntos saturate, never wrap.
  - gano and perdio can never both pulse.
- heroe_seg: SEG_SALTO when salto_act, SEG_AGACHADO when agachar_act, else SEG_PIE. Overridden by blank (7'd0) during the IMPACTO off-phase.
- Latency: impacto, gano or perdio pulse exactly 2 clk after the display_obs change that loads the hero digit.

Decomposition:
- Package heroe_pkg:
  - state encodings OFF..PA
  - SEG_PIE=7'b0011100, SEG_SALTO=7'b1100011, SEG_AGACHADO=7'b0001000
  - local FSM encodings ESPERA/JUEGO/IMPACTO/FIN
- One sub-module, sincronizador_boton: 2-flop synchronizer plus rising-edge pulse, instanced once per button.

Test Plan (SALTO_CICLOS=8, BLINK_CICLOS=8, META=3, VIDAS_INI=2):
- Low obstacle, tipo_obs=4'b0010, shifted to the hero digit with btn_salto pulsed 3 clk before arrival -> puntos 0->1, no impacto, heroe_seg=SEG_SALTO during the jump.
- High obstacle, tipo_obs=4'b0001, no buttons -> impacto pulse 2 clk after the change, vidas 2->1, IMPACTO for 8 clk with glyph blinking.
- Second hit arriving within the IMPACTO window -> vidas stays 1, no impacto pulse.
- Two hits outside IMPACTO -> vidas 0, single perdio pulse, FIN; presente=CH then GAME -> vidas=2, puntos=0.
- Three avoided obstacles, including btn_agachar held for a high one -> gano pulse exactly once at puntos=3, no further scoring.
- presente=PA held across a display_obs change, then rst_n low mid-JUEGO -> no scoring while paused; immediate async reset to vidas=2, puntos=0, heroe_seg=SEG_PIE.
